// File: rtl/cor_result_fifo_pkg.sv
// Shared tracking-engine constants used by the coherent-sum path and the
// correlation result FIFO that buffers its output words.
package cor_result_fifo_pkg;

  // Width of one correlation result word (I/Q accumulators packed).
  localparam int TRK_COR_WIDTH       = 44;
  // Default result buffer depth as a power of two.
  localparam int TRK_FIFO_DEPTH_LOG2 = 3;

  // Legal bounds for the buffer depth exponent.
  localparam int TRK_FIFO_DEPTH_LOG2_MIN = 1;
  localparam int TRK_FIFO_DEPTH_LOG2_MAX = 6;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/cor_result_fifo_if.sv
// Producer/consumer bundle for the correlation result FIFO. The master side
// (producer and consumer logic) drives requests; the slave side is the FIFO.
import cor_result_fifo_pkg::*;

// Handshake: wr_req is a request, accepted in the same cycle only when the FIFO
// is not full or a read is accepted alongside it; rd_req pops only when empty
// is low. Refused requests are dropped and latched as overflow/underflow.
interface cor_result_fifo_if #(
  parameter int DATA_WIDTH = TRK_COR_WIDTH,
  parameter int DEPTH_LOG2 = TRK_FIFO_DEPTH_LOG2
);
  logic                  flush;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_LOG2:0]   data_cnt;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_req, data_in, rd_req, err_clr,
    input  data_out, empty, full, almost_full, data_cnt, overflow, underflow
  );

  modport slave (
    input  flush, wr_req, data_in, rd_req, err_clr,
    output data_out, empty, full, almost_full, data_cnt, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port, no reset so it maps onto distributed RAM.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 44,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cor_result_fifo.sv
// Correlation result FIFO: pointer, count and sticky error logic around a
// dual-port memory, with registered or first-word-fall-through read data.
module cor_result_fifo
  import cor_result_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = TRK_COR_WIDTH,
  parameter int DEPTH_LOG2  = TRK_FIFO_DEPTH_LOG2,
  parameter int FWFT        = 0,
  parameter int AFULL_LEVEL = (1 << DEPTH_LOG2) - 2
) (
  input  logic            clk,
  input  logic            rst_b,
  cor_result_fifo_if.slave bus
);

  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  is_empty;
  logic                  is_full;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);

  // Flush swallows both requests; a write into a full FIFO is only allowed
  // when the head is popped in the same cycle.
  assign rd_ok = bus.rd_req & ~is_empty & ~bus.flush;
  assign wr_ok = bus.wr_req & (~is_full | rd_ok) & ~bus.flush;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_addr <= '0;
      rd_addr <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_addr <= '0;
      rd_addr <= '0;
      cnt     <= '0;
    end else begin
      if (wr_ok) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (rd_ok) begin
        rd_addr <= rd_addr + 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A new refusal wins over a clear arriving in the same cycle.
      if (bus.wr_req && !wr_ok) begin
        ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_q <= 1'b0;
      end
      if (bus.rd_req && !rd_ok) begin
        unf_q <= 1'b1;
      end else if (bus.err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (bus.data_in),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem_rdata;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= mem_rdata;
        end
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= AFULL_CNT);
  assign bus.data_cnt    = cnt;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_cor_result_fifo.sv
// Self-checking bench for cor_result_fifo: directed scenarios plus random
// traffic compared against a queue-based model of the FIFO.
module tb_cor_result_fifo;

  localparam int DW    = 44;
  localparam int DL2   = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int VW    = DW + 9;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  cor_result_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus0 ();
  cor_result_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus1 ();

  cor_result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .FWFT(0), .AFULL_LEVEL(AFL)) dut0 (
    .clk(clk), .rst_b(rst_b), .bus(bus0)
  );
  cor_result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .FWFT(1), .AFULL_LEVEL(AFL)) dut1 (
    .clk(clk), .rst_b(rst_b), .bus(bus1)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  logic [VW-1:0] act_vec;
  assign act_vec = {bus0.data_out, bus0.empty, bus0.full, bus0.almost_full,
                    bus0.data_cnt, bus0.overflow, bus0.underflow};

  function automatic logic [VW-1:0] exp_vec();
    int n;
    n = exp_q.size();
    return {exp_dout, (n == 0), (n == DEPTH), (n >= AFL), 4'(n), exp_ovf, exp_unf};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic model_step(input logic wr, input logic [DW-1:0] din, input logic rd,
                            input logic fl, input logic ec);
    bit rd_ok, wr_ok;
    rd_ok = rd && (exp_q.size() > 0) && !fl;
    wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok) && !fl;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(din);
      if (wr && !wr_ok) exp_ovf = 1'b1;
      else if (ec)      exp_ovf = 1'b0;
      if (rd && !rd_ok) exp_unf = 1'b1;
      else if (ec)      exp_unf = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_bus0();
    bus0.wr_req = 1'b0; bus0.rd_req = 1'b0; bus0.flush = 1'b0;
    bus0.err_clr = 1'b0; bus0.data_in = '0;
  endtask

  // One clock of stimulus on dut0; returns #1 after the edge, ready to sample.
  task automatic drive(input logic wr, input logic [DW-1:0] din, input logic rd,
                       input logic fl, input logic ec);
    bus0.wr_req = wr; bus0.data_in = din; bus0.rd_req = rd;
    bus0.flush = fl; bus0.err_clr = ec;
    @(posedge clk);
    model_step(wr, din, rd, fl, ec);
    #1;
    idle_bus0();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    vectors++;
    if (act_vec !== {{DW{1'b0}}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", act_vec,
               {{DW{1'b0}}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    end
    vectors++;
    if (bus1.empty !== 1'b1 || bus1.data_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_fwft: empty=%b cnt=%0d want 1/0", bus1.empty, bus1.data_cnt);
    end
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({bus0.full, bus0.almost_full, bus0.data_cnt} !== {(i == DEPTH), (i >= AFL), 4'(i)}) begin
        miscompares++;
        $display("FAIL fill_%0d: full/afull/cnt=%b/%b/%0d want %b/%b/%0d", i, bus0.full,
                 bus0.almost_full, bus0.data_cnt, (i == DEPTH), (i >= AFL), i);
      end
    end
    drive(1'b1, DW'(9), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus0.overflow !== 1'b1 || bus0.data_cnt !== 4'd8) begin
      miscompares++;
      $display("FAIL fill_overflow: ovf=%b cnt=%0d want 1/8", bus0.overflow, bus0.data_cnt);
    end
  endtask

  task automatic test_drain();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bus0.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clr_ovf: ovf=%b want 0", bus0.overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (bus0.data_out !== DW'(i + 1)) begin
        miscompares++;
        $display("FAIL drain_%0d: data_out=%h want %h", i, bus0.data_out, DW'(i + 1));
      end
    end
    vectors++;
    if (bus0.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: empty=%b want 1", bus0.empty);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus0.underflow !== 1'b1 || bus0.data_out !== DW'(8)) begin
      miscompares++;
      $display("FAIL drain_underflow: unf=%b data_out=%h want 1/8", bus0.underflow, bus0.data_out);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL err_clr_unf: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] first;
    first = {$urandom, $urandom};
    drive(1'b1, first, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    drive(1'b1, DW'('hA), 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus0.data_cnt !== 4'd8 || bus0.overflow !== 1'b0 || bus0.data_out !== first) begin
      miscompares++;
      $display("FAIL full_rw: cnt=%0d ovf=%b data_out=%h want 8/0/%h", bus0.data_cnt,
               bus0.overflow, bus0.data_out, first);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL full_rw_rd_%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus0.data_out !== DW'('hA) || bus0.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_rw_last: data_out=%h empty=%b want a/1", bus0.data_out, bus0.empty);
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, DW'(5), 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus0.underflow !== 1'b1 || bus0.data_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL empty_rw: unf=%b cnt=%0d want 1/1", bus0.underflow, bus0.data_cnt);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (bus0.data_out !== DW'(5) || bus0.underflow !== 1'b0 || bus0.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rw_read: data_out=%h unf=%b empty=%b want 5/0/1", bus0.data_out,
               bus0.underflow, bus0.empty);
    end
  endtask

  task automatic test_fwft();
    bus1.wr_req = 1'b1; bus1.data_in = DW'('h33);
    @(posedge clk); #1;
    bus1.wr_req = 1'b0; bus1.data_in = '0;
    vectors++;
    if (bus1.empty !== 1'b0 || bus1.data_out !== DW'('h33)) begin
      miscompares++;
      $display("FAIL fwft_head: empty=%b data_out=%h want 0/33", bus1.empty, bus1.data_out);
    end
    bus1.wr_req = 1'b1; bus1.data_in = DW'('h44);
    @(posedge clk); #1;
    bus1.wr_req = 1'b0;
    vectors++;
    if (bus1.data_out !== DW'('h33) || bus1.data_cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL fwft_hold: data_out=%h cnt=%0d want 33/2", bus1.data_out, bus1.data_cnt);
    end
    bus1.rd_req = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus1.data_out !== DW'('h44) || bus1.empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop1: data_out=%h empty=%b want 44/0", bus1.data_out, bus1.empty);
    end
    @(posedge clk); #1;
    bus1.rd_req = 1'b0;
    vectors++;
    if (bus1.empty !== 1'b1 || bus1.underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fwft_pop2: empty=%b unf=%b want 1/0", bus1.empty, bus1.underflow);
    end
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'b0, 1'b0);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 3; i++) begin
      if (exp_q.size() < 3) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      else                  drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    vectors++;
    if (bus0.data_cnt !== 4'd3) begin
      miscompares++;
      $display("FAIL pre_flush_cnt: cnt=%0d want 3", bus0.data_cnt);
    end
    drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (bus0.data_cnt !== 4'd0 || bus0.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: cnt=%0d empty=%b want 0/1", bus0.data_cnt, bus0.empty);
    end
    vectors++;
    if (act_vec !== exp_vec()) begin
      miscompares++;
      $display("FAIL flush_state: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 9) < 6), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 9) == 0));
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, '1, 1'b1, 1'b0, 1'b0);
    bus0.wr_req = 1'b1; bus0.data_in = DW'('h5A5); bus0.rd_req = 1'b1;
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    vectors++;
    if (act_vec !== {{DW{1'b0}}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", act_vec,
               {{DW{1'b0}}, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    end
    idle_bus0();
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    drive(1'b1, DW'('h77), 1'b0, 1'b0, 1'b0);
    drive(1'b1, DW'('h88), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (act_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL post_reset_rd_%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle_bus0();
    bus1.wr_req = 1'b0; bus1.rd_req = 1'b0; bus1.flush = 1'b0;
    bus1.err_clr = 1'b0; bus1.data_in = '0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_wrap_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cor_result_fifo.md
COR_RESULT_FIFO -- requirements
Module: cor_result_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 44, correlation result word width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, depth = 2^DEPTH_LOG2 entries; legal range 1..6.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_LEVEL, default 2^DEPTH_LOG2-2; almost_full threshold.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst_b  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents and pointers.
REQ-008 SHALL have port wr_req  input  1  write request.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rd_req  input  1  read (pop) request.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  read data.
REQ-012 SHALL have port empty  output  1  no stored entries.
REQ-013 SHALL have port full  output  1  2^DEPTH_LOG2 stored entries.
REQ-014 SHALL have port almost_full  output  1  data_cnt >= AFULL_LEVEL.
REQ-015 SHALL have port data_cnt  output  DEPTH_LOG2+1  stored entry count, 0..2^DEPTH_LOG2.
REQ-016 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-017 SHALL have port overflow  output  1  sticky: write refused.
REQ-018 SHALL have port underflow  output  1  sticky: read refused.

Function
REQ-019 SHALL accept a write (wr_ok) when wr_req & (!full | rd_ok); data stored at wr_addr, wr_addr increments modulo depth.
REQ-020 SHALL accept a read (rd_ok) when rd_req & !empty; rd_addr increments modulo depth.
REQ-021 SHALL, on read with empty high, refuse the read even if wr_req is high the same cycle; the written word is stored.
REQ-022 SHALL update data_cnt by +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither; never exceeds range.
REQ-023 SHALL derive empty, full, almost_full combinationally from registered data_cnt.
REQ-024 SHALL, with FWFT=0, load data_out with mem[rd_addr] on the clock edge of rd_ok (1-cycle latency), else hold.
REQ-025 SHALL, with FWFT=1, drive data_out = mem[rd_addr] continuously; head word valid whenever empty is low; rd_ok pops it.
REQ-026 SHALL set overflow on wr_req & !wr_ok, underflow on rd_req & !rd_ok; both hold until err_clr.
REQ-027 SHALL give a same-cycle set event priority over err_clr.
REQ-028 SHALL, on flush, zero rd_addr, wr_addr, data_cnt; ignore wr_req/rd_req that cycle; not raise errors; leave data_out and error flags unchanged.
REQ-029 SHALL not require memory contents to be reset.

Reset
REQ-030 SHALL, on rst_b low, asynchronously clear rd_addr, wr_addr, data_cnt, data_out, overflow, underflow to 0 (empty=1, full=0, almost_full=0).
REQ-031 SHALL discard any in-flight read/write when reset asserts mid-operation; first accepted write after release goes to address 0.

Structure
REQ-032 SHALL take default DATA_WIDTH and DEPTH_LOG2 values from the shared tracking-engine constants package used by the coherent-sum path.
REQ-033 SHALL place storage in one sub-module fifo_mem_dp (1 write port, 1 async read port, no reset), instantiated once.
REQ-034 SHALL keep pointer/count/flag logic in cor_result_fifo itself.

Verification
REQ-035 SHALL check: DEPTH_LOG2=3, FWFT=0, write 8 words 0x1..0x8 -> full=1, data_cnt=8, almost_full from count 6; 9th write -> overflow=1, count stays 8.
REQ-036 SHALL check: FWFT=0, 8 reads from full -> data_out 0x1..0x8 each one cycle after rd_req, then empty=1; extra read -> underflow=1, data_out holds 0x8.
REQ-037 SHALL check: full plus simultaneous wr_req&rd_req with 0xA -> both accepted, count 8, no overflow; 0xA read back after 7 more words.
REQ-038 SHALL check: empty plus simultaneous wr_req&rd_req with 0x5 -> read refused, underflow=1, count 1, next read returns 0x5.
REQ-039 SHALL check: FWFT=1, write 0x33 -> next cycle empty=0 and data_out=0x33 with no rd_req; pop -> empty=1.
REQ-040 SHALL check: 20 write/read cycles to wrap pointers, then flush with count 3 -> count 0, empty=1; rst_b pulse mid-burst -> all outputs 0.
